// File: rtl/compare_rr_scheduler_pkg.sv
// rtl/compare_rr_scheduler_pkg.sv - shared state encodings and defaults for the comparator scheduler
package compare_rr_scheduler_pkg;

    localparam int NREQ_DEFAULT  = 4;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LATCH   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Pointer width for 2..8 requesters
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : ((n <= 4) ? 2 : 3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or after ptr, circular
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [PTR_W-1:0] win_idx,
    output logic             any_req
);

    int   idx_c;
    logic found_c;

    assign any_req = |req;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found_c    = 1'b0;
        idx_c      = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx_c = int'(ptr) + off;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            if (!found_c && req[idx_c]) begin
                found_c            = 1'b1;
                win_idx            = PTR_W'(idx_c);
                win_onehot[idx_c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/two_bit_inequality.sv
// rtl/two_bit_inequality.sv - combinational unsigned 2-bit A>B comparator
module two_bit_inequality (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);

    assign gt = (a[1] & ~b[1])
              | (a[0] & ~b[1] & ~b[0])
              | (a[1] & a[0] & ~b[0]);

endmodule

// File: rtl/compare_rr_scheduler.sv
// rtl/compare_rr_scheduler.sv - round-robin sharing of one 2-bit A>B comparator among NREQ requesters
module compare_rr_scheduler
    import compare_rr_scheduler_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] a_bus,
    input  logic [2*NREQ-1:0] b_bus,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              gt_out,
    output logic              busy,
    output logic [CNT_W-1:0]  cmp_count
);

    localparam int PTR_W = ptr_width(NREQ);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_r;
    logic [NREQ-1:0]    grant_r;
    logic [1:0]         a_r, b_r;
    logic [NREQ-1:0]    arb_onehot;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic               cmp_gt;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .any_req    (arb_any)
    );

    two_bit_inequality u_cmp (
        .a  (a_r),
        .b  (b_r),
        .gt (cmp_gt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arb_any) state_nxt = S_LATCH;
            S_LATCH:   state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // gt_out is loaded on entry to DONE so it is already valid while done pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            win_r     <= '0;
            grant_r   <= '0;
            a_r       <= '0;
            b_r       <= '0;
            gt_out    <= 1'b0;
            cmp_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        win_r   <= arb_idx;
                        grant_r <= arb_onehot;
                    end
                end
                S_LATCH: begin
                    a_r <= a_bus[{win_r, 1'b0} +: 2];
                    b_r <= b_bus[{win_r, 1'b0} +: 2];
                end
                S_COMPARE: begin
                    gt_out <= cmp_gt;
                end
                S_DONE: begin
                    cmp_count <= cmp_count + CNT_W'(1);
                    rr_ptr    <= (win_r == PTR_W'(NREQ - 1)) ? '0 : win_r + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign grant = (state != S_IDLE) ? grant_r : '0;
    assign done  = (state == S_DONE) ? grant_r : '0;

endmodule

// File: tb/tb_compare_rr_scheduler.sv
// tb/tb_compare_rr_scheduler.sv - directed self-checking bench for compare_rr_scheduler
module tb_compare_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] a_bus;
    logic [7:0] b_bus;
    logic [3:0] grant;
    logic [3:0] done;
    logic       gt_out;
    logic       busy;
    logic [7:0] cmp_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] gt_tab;

    compare_rr_scheduler #(.NREQ(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .grant     (grant),
        .done      (done),
        .gt_out    (gt_out),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge in IDLE; req held until its done
    task automatic do_op(input int idx, input logic [1:0] a, input logic [1:0] b,
                         input logic exp_gt, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        a_bus[2*idx +: 2] = a;
        b_bus[2*idx +: 2] = b;
        req[idx] = 1'b1;
        @(negedge clk);
        chk({tag, " grant"}, {28'd0, grant}, {28'd0, oh});
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, " done"}, {28'd0, done}, {28'd0, oh});
        chk({tag, " gt"}, {31'd0, gt_out}, {31'd0, exp_gt});
        req[idx] = 1'b0;
        @(negedge clk);
        chk({tag, " done_low"}, {28'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        a_bus = 8'h00;
        b_bus = 8'h00;
        gt_tab = 16'h7310;
        repeat (3) @(negedge clk);

        chk("rst busy",  {31'd0, busy}, 32'd0);
        chk("rst grant", {28'd0, grant}, 32'd0);
        chk("rst done",  {28'd0, done}, 32'd0);
        chk("rst gt",    {31'd0, gt_out}, 32'd0);
        chk("rst count", {24'd0, cmp_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request, A=3 B=2
        do_op(0, 2'd3, 2'd2, 1'b1, "t1");
        chk("t1 count", {24'd0, cmp_count}, 32'd1);

        // Exhaustive A/B table via requester 1
        for (int i = 0; i < 16; i++) begin
            do_op(1, 2'(i / 4), 2'(i % 4), gt_tab[i], $sformatf("t2 a%0d b%0d", i / 4, i % 4));
        end
        chk("t2 count", {24'd0, cmp_count}, 32'd17);

        // All four requesting continuously from ptr=0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_bus = 8'h00;
        b_bus = 8'h00;
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("t3 grant%0d", k), {28'd0, grant}, {28'd0, 4'b0001 << (k % 4)});
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("t3 done%0d", k), {28'd0, done}, {28'd0, 4'b0001 << (k % 4)});
            @(negedge clk);
            chk($sformatf("t3 width%0d", k), {28'd0, done}, 32'd0);
        end
        req = 4'b0000;
        chk("t3 count", {24'd0, cmp_count}, 32'd16);

        // Move ptr to 2, then req=0011 must serve 0 first
        do_op(1, 2'd0, 2'd0, 1'b0, "t4 setup");
        req = 4'b0011;
        @(negedge clk);
        chk("t4 grant0", {28'd0, grant}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t4 done0", {28'd0, done}, 32'd1);
        req = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        chk("t4 grant3", {28'd0, grant}, 32'd8);
        @(negedge clk);
        @(negedge clk);
        chk("t4 done3", {28'd0, done}, 32'd8);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("t4 grant0b", {28'd0, grant}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t4 done0b", {28'd0, done}, 32'd1);
        req = 4'b0000;
        @(negedge clk);

        // Reset during COMPARE aborts the op
        a_bus[5:4] = 2'd3;
        b_bus[5:4] = 2'd0;
        req = 4'b0100;
        @(negedge clk);
        chk("t5 grant", {28'd0, grant}, 32'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b0000;
        chk("t5 busy",  {31'd0, busy}, 32'd0);
        chk("t5 grant0", {28'd0, grant}, 32'd0);
        chk("t5 done",  {28'd0, done}, 32'd0);
        chk("t5 gt",    {31'd0, gt_out}, 32'd0);
        chk("t5 count", {24'd0, cmp_count}, 32'd0);
        @(negedge clk);
        chk("t5 no_done", {28'd0, done}, 32'd0);

        // Operand change after LATCH is ignored
        a_bus[1:0] = 2'd1;
        b_bus[1:0] = 2'd1;
        req = 4'b0001;
        @(negedge clk);
        chk("t6 grant", {28'd0, grant}, 32'd1);
        @(negedge clk);
        a_bus[1:0] = 2'd3;
        @(negedge clk);
        chk("t6 done", {28'd0, done}, 32'd1);
        chk("t6 gt",   {31'd0, gt_out}, 32'd0);
        @(negedge clk);
        chk("t6 count1", {24'd0, cmp_count}, 32'd1);

        // Counter wrap after 256 completed ops
        repeat (254 * 4) @(negedge clk);
        chk("t6 count255", {24'd0, cmp_count}, 32'd255);
        repeat (4) @(negedge clk);
        req = 4'b0000;
        chk("t6 wrap", {24'd0, cmp_count}, 32'd0);
        @(negedge clk);
        chk("t6 idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
